// File: rtl/act_pack_writeback.sv
// act_pack_writeback: snapshots the PE accumulator results, applies the
// per-layer activation, streams them out as packed words over a valid/ready
// write port, and tracks the running argmax for classification.

// Single-result activation: 00/11 pass, 01 ReLU, 10 ReLU then clip at CLAMP_MAX.
module act_lane #(
    parameter int                      ACC_W     = 16,
    parameter logic signed [ACC_W-1:0] CLAMP_MAX = 16'sd4096
) (
    input  logic [1:0]              sel,
    input  logic signed [ACC_W-1:0] x,
    output logic signed [ACC_W-1:0] y
);
    // Pure combinational select; no width growth, results saturate in place.
    always_comb begin
        y = x;
        case (sel)
            2'b01: if (x < 0) y = '0;
            2'b10: begin
                if (x < 0)              y = '0;
                else if (x > CLAMP_MAX) y = CLAMP_MAX;
            end
            default: y = x;
        endcase
    end
endmodule

module act_pack_writeback #(
    parameter int                      NUM_ACC   = 32,
    parameter int                      ACC_W     = 16,
    parameter int                      LANES     = 4,
    parameter int                      ADDR_W    = 10,
    parameter logic signed [ACC_W-1:0] CLAMP_MAX = 16'sd4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 act_sel,
    input  logic [NUM_ACC*ACC_W-1:0]   acc_bus,
    input  logic [ADDR_W-1:0]          wb_base_addr,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [LANES*ACC_W-1:0]     wr_data,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_ACC)-1:0] max_idx
);
    localparam int NUM_WORDS = NUM_ACC / LANES;
    localparam int K_W       = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int IDX_W     = $clog2(NUM_ACC);

    typedef enum logic [1:0] {IDLE, ACT, SEND, DONE} state_t;

    state_t                                     state;
    logic [NUM_WORDS-1:0][LANES-1:0][ACC_W-1:0] snap;
    logic [NUM_WORDS-1:0][LANES-1:0][ACC_W-1:0] act_q;
    logic [NUM_WORDS-1:0][LANES-1:0][ACC_W-1:0] act_d;
    logic [1:0]                                 sel_q;
    logic [ADDR_W-1:0]                          base_q;
    logic [K_W-1:0]                             k;
    logic signed [ACC_W-1:0]                    best_val;
    logic [IDX_W-1:0]                           best_idx;
    logic signed [ACC_W-1:0]                    cand_val;
    logic [IDX_W-1:0]                           cand_idx;
    logic                                       accept;
    logic                                       last_word;

    assign accept    = wr_valid && wr_ready;
    assign last_word = (k == K_W'(NUM_WORDS - 1));

    // One activation unit per accumulator result, all fed from the snapshot.
    for (genvar i = 0; i < NUM_ACC; i++) begin : g_lane
        act_lane #(.ACC_W(ACC_W), .CLAMP_MAX(CLAMP_MAX)) u_lane (
            .sel (sel_q),
            .x   (snap[i/LANES][i%LANES]),
            .y   (act_d[i/LANES][i%LANES])
        );
    end

    // Argmax over the presented word's lanes in order; strict > keeps the lowest index on ties.
    always_comb begin
        cand_val = best_val;
        cand_idx = best_idx;
        for (int j = 0; j < LANES; j++) begin
            if ($signed(act_q[k][j]) > cand_val) begin
                cand_val = $signed(act_q[k][j]);
                cand_idx = IDX_W'(int'(k) * LANES + j);
            end
        end
    end

    // Address wraps naturally at ADDR_W bits; port reads as zero when not requesting.
    assign wr_addr = wr_valid ? base_q + ADDR_W'(k) : '0;
    assign wr_data = wr_valid ? act_q[k] : '0;

    // Pass sequencer: snapshot, activate, stream words, pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            snap     <= '0;
            act_q    <= '0;
            sel_q    <= '0;
            base_q   <= '0;
            k        <= '0;
            best_val <= '0;
            best_idx <= '0;
            wr_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            max_idx  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        snap     <= acc_bus;
                        sel_q    <= act_sel;
                        base_q   <= wb_base_addr;
                        k        <= '0;
                        best_val <= {1'b1, {(ACC_W-1){1'b0}}};
                        best_idx <= '0;
                        busy     <= 1'b1;
                        state    <= ACT;
                    end
                end
                ACT: begin
                    act_q    <= act_d;
                    wr_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (accept) begin
                        k        <= k + 1'b1;
                        best_val <= cand_val;
                        best_idx <= cand_idx;
                        if (last_word) begin
                            wr_valid <= 1'b0;
                            max_idx  <= cand_idx;
                            done     <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_act_pack_writeback.sv
// Directed bench for act_pack_writeback: ReLU/clamp/feed-through passes,
// backpressure, address wrap, ignored restart and mid-pass reset.
module tb_act_pack_writeback;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   act_sel;
    logic [511:0] acc_bus;
    logic [9:0]   wb_base_addr;
    logic         wr_valid;
    logic         wr_ready;
    logic [9:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         busy;
    logic         done;
    logic [4:0]   max_idx;

    logic signed [15:0] acc [32];
    for (genvar g = 0; g < 32; g++) begin : g_bus
        assign acc_bus[g*16 +: 16] = acc[g];
    end

    always #5 clk = ~clk;

    act_pack_writeback dut (
        .clk(clk), .rst(rst), .start(start), .act_sel(act_sel),
        .acc_bus(acc_bus), .wb_base_addr(wb_base_addr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .max_idx(max_idx)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected results computed from the bench's own copy of the stimulus
    logic [63:0] exp_word [8];
    logic [4:0]  exp_max;
    logic [9:0]  cur_base;

    function automatic logic signed [15:0] ref_act(input logic [1:0] sel, input logic signed [15:0] x);
        case (sel)
            2'b01:   return (x < 0) ? 16'sd0 : x;
            2'b10:   return (x < 0) ? 16'sd0 : ((x > 16'sd4096) ? 16'sd4096 : x);
            default: return x;
        endcase
    endfunction

    task automatic build_exp(input logic [1:0] sel);
        logic signed [15:0] v;
        logic signed [15:0] best;
        best    = 16'sh8000;
        exp_max = '0;
        for (int i = 0; i < 32; i++) begin
            v = ref_act(sel, acc[i]);
            exp_word[i/4][(i%4)*16 +: 16] = v;
            if (v > best) begin
                best    = v;
                exp_max = 5'(i);
            end
        end
    endtask

    // Observed transfer log
    logic [9:0]  g_addr [8];
    logic [63:0] g_data [8];
    int          g_cyc  [8];
    int          nw;
    int          done_cyc;
    int          busy_bad;
    logic [4:0]  g_max;

    task automatic setup(input logic [1:0] sel, input logic [9:0] base);
        act_sel      = sel;
        wb_base_addr = base;
        cur_base     = base;
        build_exp(sel);
    endtask

    // One pass: start at edge 0, then watch each cycle on the falling edge.
    task automatic run_pass(input int stall_n, input int restart_cyc, input int rst_after,
                            output bit aborted);
        int stall_left;
        stall_left = stall_n;
        nw = 0; done_cyc = -1; busy_bad = 0; aborted = 1'b0; g_max = 'x;
        @(negedge clk);
        start = 1'b1; wr_ready = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc < 60 && done_cyc < 0 && !aborted; cyc++) begin
            @(negedge clk);
            if (!busy) busy_bad++;
            if (cyc == restart_cyc) begin
                start = 1'b1;
                for (int i = 0; i < 32; i++) acc[i] = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            if (rst_after >= 0 && nw == rst_after && wr_valid) begin
                rst = 1'b1;
                #1;
                chk("rst_wr_valid", 64'(wr_valid), 64'd0);
                chk("rst_busy",     64'(busy),     64'd0);
                chk("rst_done",     64'(done),     64'd0);
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
            end else if (wr_valid) begin
                if (nw == 2 && stall_left > 0) begin
                    wr_ready = 1'b0;
                    stall_left--;
                    chk("stall_addr", 64'(wr_addr), 64'(cur_base + 10'd2));
                    chk("stall_data", wr_data, exp_word[2]);
                end else begin
                    wr_ready = 1'b1;
                    if (nw < 8) begin
                        g_addr[nw] = wr_addr;
                        g_data[nw] = wr_data;
                        g_cyc[nw]  = cyc;
                    end
                    nw++;
                end
            end else begin
                wr_ready = 1'b1;
            end
            if (done) begin
                done_cyc = cyc;
                g_max    = max_idx;
            end
        end
        start    = 1'b0;
        wr_ready = 1'b1;
    endtask

    task automatic check_pass(input int stall_n);
        logic [9:0] ea;
        chk("done_cycle",  64'(done_cyc), 64'(10 + stall_n));
        chk("num_words",   64'(nw),       64'd8);
        chk("busy_window", 64'(busy_bad), 64'd0);
        chk("max_idx",     64'(g_max),    64'(exp_max));
        for (int k = 0; k < 8; k++) begin
            ea = cur_base + 10'(k);
            chk($sformatf("addr%0d", k), 64'(g_addr[k]), 64'(ea));
            chk($sformatf("data%0d", k), g_data[k], exp_word[k]);
            chk($sformatf("cyc%0d", k),  64'(g_cyc[k]), 64'(2 + k + ((k >= 2) ? stall_n : 0)));
        end
        @(negedge clk);
        chk("busy_after", 64'(busy), 64'd0);
        chk("done_after", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        chk("max_hold", 64'(max_idx), 64'(exp_max));
    endtask

    bit ab;

    initial begin
        rst = 1'b1; start = 1'b0; wr_ready = 1'b1; act_sel = '0; wb_base_addr = '0; cur_base = '0;
        for (int i = 0; i < 32; i++) acc[i] = '0;
        repeat (2) @(negedge clk);
        chk("reset_wr_valid", 64'(wr_valid), 64'd0);
        chk("reset_wr_addr",  64'(wr_addr),  64'd0);
        chk("reset_wr_data",  wr_data,       64'd0);
        chk("reset_busy",     64'(busy),     64'd0);
        chk("reset_done",     64'(done),     64'd0);
        chk("reset_max_idx",  64'(max_idx),  64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: ReLU ramp
        for (int i = 0; i < 32; i++) acc[i] = 16'(i - 16);
        setup(2'b01, 10'h100);
        run_pass(0, -1, -1, ab);
        check_pass(0);
        chk("t1_word0", g_data[0], 64'h0000_0000_0000_0000);
        chk("t1_word7", g_data[7], 64'h000F_000E_000D_000C);
        chk("t1_max",   64'(g_max), 64'd31);

        // 2: backpressure on word 2
        run_pass(3, -1, -1, ab);
        check_pass(3);
        chk("t2_word7", g_data[7], 64'h000F_000E_000D_000C);

        // 3: feed-through of the most negative value
        for (int i = 0; i < 32; i++) acc[i] = 16'sh8000;
        setup(2'b00, 10'h040);
        run_pass(0, -1, -1, ab);
        check_pass(0);
        chk("t3_word3", g_data[3], 64'h8000_8000_8000_8000);
        chk("t3_max",   64'(g_max), 64'd0);

        // 4: clamp with tie at CLAMP_MAX
        for (int i = 0; i < 32; i++) acc[i] = '0;
        acc[0] = 16'sd5000; acc[1] = -16'sd3; acc[2] = 16'sd4096;
        setup(2'b10, 10'h200);
        run_pass(0, -1, -1, ab);
        check_pass(0);
        chk("t4_word0", g_data[0], 64'h0000_1000_0000_1000);
        chk("t4_max",   64'(g_max), 64'd0);

        // 5: address wrap
        for (int i = 0; i < 32; i++) acc[i] = 16'(i * 3 - 40);
        setup(2'b11, 10'h3FE);
        run_pass(0, -1, -1, ab);
        check_pass(0);
        chk("t5_addr1", 64'(g_addr[1]), 64'h3FF);
        chk("t5_addr2", 64'(g_addr[2]), 64'h000);
        chk("t5_addr7", 64'(g_addr[7]), 64'h005);

        // 6a: restart request in cycle 4 with a changing bus
        for (int i = 0; i < 32; i++) acc[i] = 16'((i * 37) % 200 - 100);
        setup(2'b01, 10'h080);
        run_pass(0, 4, -1, ab);
        check_pass(0);

        // 6b: reset after three accepted words, then a clean pass
        for (int i = 0; i < 32; i++) acc[i] = 16'(100 - i * 7);
        setup(2'b10, 10'h010);
        run_pass(0, -1, 3, ab);
        chk("rst_no_done",     64'(done_cyc), 64'(-1));
        chk("rst_words",       64'(nw),       64'd3);
        chk("rst_max_cleared", 64'(max_idx),  64'd0);
        run_pass(0, -1, -1, ab);
        check_pass(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/act_pack_writeback.md
Name: act_pack_writeback

Overview:
- Downstream stage of the PE array. It snapshots the 32 signed accumulator results (8 PEs x 4) and applies the per-layer activation.
- It packs 4 results per 64-bit word and writes the 8 words back to a memory bank through a valid/ready write port.
- It tracks the running argmax of the activated values, which supplies the classification result for the output layer.
- `main_control` drives `start`, `act_sel` and `wb_base_addr`; the memory bank write port is the sink.

Parameters:
- NUM_ACC, 32, number of accumulator results consumed per pass (multiple of LANES).
- ACC_W, 16, accumulator/result width, signed two's complement.
- LANES, 4, results packed per write word (WORD_W = LANES*ACC_W = 64).
- ADDR_W, 10, memory word address width.
- CLAMP_MAX, 16'sd4096, upper clip value for clamp activation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- act_sel  in  2  activation select: 00 feed-through, 01 ReLU, 10 clamp (ReLU then min CLAMP_MAX), 11 treated as feed-through.
- acc_bus  in  NUM_ACC*ACC_W  flattened PE results; result i at [i*ACC_W +: ACC_W].
- wb_base_addr  in  ADDR_W  first write address.
- wr_valid  out  1  write request.
- wr_ready  in  1  memory accepts the word when high together with wr_valid.
- wr_addr  out  ADDR_W  write word address.
- wr_data  out  64  packed word k; lane j at [j*16 +: 16] = activated result LANES*k+j.
- busy  out  1  high from the cycle after start is accepted until done, inclusive.
- done  out  1  single-cycle pulse at pass completion.
- max_idx  out  5  index of the largest activated result; valid from done until the next start.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; word counter, snapshot and argmax registers cleared.
- FSM states: IDLE, ACT, SEND, DONE.
- IDLE -> ACT: on start at edge E.
  - At E, latch acc_bus into the snapshot, and latch act_sel and wb_base_addr.
  - Set word k=0, best_val=16'sh8000, best_idx=0.
- ACT (1 cycle): compute activation on all 32 snapshot entries and register the results.
  - ReLU: negative -> 0.
  - Clamp: negative -> 0, >CLAMP_MAX -> CLAMP_MAX.
  - No width growth; no rounding.
- SEND:
  - wr_valid=1, wr_addr=base+k (mod 2^ADDR_W), wr_data=word k.
  - wr_addr and wr_data stay stable while wr_ready=0.
  - On wr_valid&&wr_ready: k increments.
  - In the same edge, the argmax updates over the 4 lanes of word k in lane order, using strict signed > so ties keep the lowest index.
  - After word NUM_ACC/LANES-1 is accepted -> DONE; wr_valid deasserts at that edge.
- DONE (1 cycle): done=1, max_idx=best_idx; then -> IDLE.
  - busy drops with the return to IDLE.
- Latency: with wr_ready=1 throughout and start at edge 0:
  - ACT in cycle 1.
  - SEND in cycles 2-9, one word per cycle.
  - done in cycle 10.
  - busy high in cycles 1-10.
- start while not IDLE: ignored; the snapshot is not disturbed.
- The PE array may change acc_bus any time after the start edge; the block uses only the snapshot.
- rst mid-pass: outputs go to 0 immediately (async), no done is issued, and the FSM returns to IDLE. Words already accepted are not rolled back.
- Address wrap: base+k wraps modulo 2^ADDR_W with no error flag.
- max_idx holds its value across IDLE and is cleared only by rst or overwritten at the next DONE.

Test Plan:
1. ReLU, acc i = i-16, base 0x100, wr_ready=1, start at cycle 0:
   - Writes to 0x100..0x107 in cycles 2-9.
   - Word0 = 0x0000_0000_0000_0000; word7 = {16'd15,16'd14,16'd13,16'd12}.
   - done in cycle 10; max_idx=31.
2. Backpressure, same stimulus with wr_ready low for 3 cycles while word 2 is presented:
   - wr_addr held at 0x102 and wr_data held for those cycles.
   - done moves to cycle 13; contents identical to scenario 1.
3. Feed-through, all acc = 16'sh8000:
   - Every word is 0x8000_8000_8000_8000.
   - max_idx=0 (tie rule).
4. Clamp, acc0=5000, acc1=-3, acc2=4096, all others 0:
   - Word0 = {16'd0,16'd4096,16'd0,16'd4096}.
   - max_idx=0 (tie with acc2 resolves to the lower index).
5. Base 0x3FE: addresses 0x3FE, 0x3FF, 0x000 .. 0x005 in order.
6. Robustness, in two parts:
   - Second start pulse in cycle 4 while acc_bus changes: ignored; outputs match the first snapshot.
   - rst asserted after 3 words accepted: wr_valid, busy and done go to 0 immediately with no done pulse; a subsequent start completes a full 8-word pass.
